// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-access stage.
// Turns an effective address plus size code into a single word-wide memory
// transaction, aligns store lanes and byte enables, and extends load data.
// Memory handshake: mem_req is the valid; once raised it stays high with every
// mem_* output frozen until mem_ready is sampled high on a rising edge, which
// completes the transfer. mem_ready has no meaning while mem_req is low.
// Faulting ops (misaligned or illegal size code) never touch memory and
// complete one cycle after start with err set.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        dbg_state
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] load_data_q, load_data_d;

    logic [1:0]  off;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Decode the incoming request: fault detection, byte enables, store lanes.
    always_comb begin
        off        = addr[1:0];
        illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                     (funct3 == 3'b111) || (funct3[2] && is_store);
        misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                     ((funct3[1:0] == 2'b10) && (off != 2'b00));
        be_dec     = 4'b0000;
        wdata_dec  = 32'h0;
        case (funct3[1:0])
            2'b00: begin
                be_dec    = 4'b0001 << off;
                wdata_dec = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_dec    = off[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{store_data[15:0]}};
            end
            2'b10: begin
                be_dec    = 4'b1111;
                wdata_dec = store_data;
            end
            default: begin
                be_dec    = 4'b0000;
                wdata_dec = 32'h0;
            end
        endcase
    end

    // Pick the addressed byte/half from the returned word and extend it.
    always_comb begin
        byte_sel = mem_rdata[8*off_q +: 8];
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // Next-state logic: accept in IDLE, wait for the acknowledge in ACCESS.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        off_d       = off_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (illegal || misaligned) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        we_d    = is_store;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = be_dec;
                        wdata_d = is_store ? wdata_dec : 32'h0;
                        f3_d    = funct3;
                        off_d   = off;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        load_data_d = load_ext;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            done_q      <= done_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
        end
    end

    // Memory outputs are gated by state so IDLE drives all zeros and an
    // asynchronous reset drops the request immediately.
    always_comb begin
        busy      = (state_q == ACCESS);
        mem_req   = busy;
        mem_we    = busy & we_q;
        mem_addr  = busy ? addr_q  : 32'h0;
        mem_be    = busy ? be_q    : 4'b0000;
        mem_wdata = busy ? wdata_q : 32'h0;
        done      = done_q;
        err       = err_q;
        load_data = load_data_q;
        dbg_state = state_q;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage that consumes the ALU result as an effective address and performs RV32I loads and stores against a word-wide data memory with a ready handshake. It aligns store data and byte enables, and sign- or zero-extends load data. It detects misaligned accesses and illegal size encodings. It holds the pipeline, through `busy`, until the memory acknowledges.

## Interface
- No parameters; all datapaths are 32 bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request from execute stage. Sampled only when `busy`=0.
- `is_store`  in  1  1 = store, 0 = load.
- `funct3`  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- `addr`  in  32  effective address (ALU `out`).
- `store_data`  in  32  rs2 value.
- `busy`  out  1  access in progress. `busy` = (state == ACCESS).
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid only with `done`; 1 = misaligned or illegal `funct3`.
- `load_data`  out  32  extended load result; valid from the `done` cycle.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  read data; valid when `mem_ready`=1.
- `mem_ready`  in  1  memory acknowledge.

## Operation
- FSM states:
  - IDLE, the reset state.
  - ACCESS, entered when a legal, aligned op is accepted.
- Let `off` = `addr[1:0]`. The access is misaligned if H/HU has `off[0]`=1, or W has `off`≠0.
- `funct3` is illegal if it is 011, 110 or 111, or if it is 1xx with `is_store`=1.
- IDLE with `start`=1:
  - Illegal or misaligned op: no memory request; next cycle `done`=1 and `err`=1; `load_data` unchanged.
  - Otherwise: latch the op, drive `mem_*` from registers, go to ACCESS.
- ACCESS: hold `mem_req`=1 with all `mem_*` outputs stable until `mem_ready`=1 is sampled. Then go to IDLE, and in the next cycle assert `done`=1 with `err`=0.
- Byte enables:
  - B/BU: `4'b0001 << off`.
  - H/HU: `off[1]` ? 1100 : 0011.
  - W: 1111.
  - Loads drive the same `mem_be` pattern with `mem_we`=0.
- Store data:
  - B: `{4{store_data[7:0]}}`.
  - H: `{2{store_data[15:0]}}`.
  - W: `store_data`.
- Load extraction is registered on the `mem_ready` cycle:
  - B/BU select lane `mem_rdata[8*off +: 8]`.
  - H/HU select the half `off[1]` ? [31:16] : [15:0].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- Stores leave `load_data` unchanged.
- `mem_ready` is ignored whenever `mem_req`=0.
- `start` is ignored while `busy`=1.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_be`, `mem_wdata`, `load_data` = 0.
- In IDLE, all `mem_*` outputs are 0.
- Start in cycle T, legal op:
  - `mem_req`=1 from T+1.
  - If `mem_ready`=1 first in cycle T+k (k≥1), then `done` is asserted in T+k+1 and `mem_req`=0 in T+k+1.
  - Minimum latency is 2 cycles.
- Start in cycle T, faulting op: `done`=`err`=1 in T+1. `busy` is never asserted.
- In the `done` cycle the FSM is already IDLE, so a new `start` is accepted back-to-back.
- `start` and `mem_ready` arriving in the same cycle in IDLE: `mem_ready` is ignored and `start` is accepted.
- Reset mid-ACCESS: `mem_req` and `busy` drop immediately (asynchronous). The transaction is abandoned and no `done` is generated.
- `done` and `err` are high for exactly one cycle.

## Test plan
- SW with `addr`=0x104 and `store_data`=0xDEADBEEF; `mem_ready` high 3 cycles after `mem_req` rises.
  - Expect `mem_addr`=0x104, `mem_be`=1111, `mem_we`=1 and `mem_wdata`=0xDEADBEEF held stable.
  - Expect `done` in the cycle after ack, with `err`=0.
- SB with `addr`=0x203 and `store_data`=0x000000A5.
  - Expect `mem_addr`=0x200, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5.
- Loads from `mem_rdata`=0x80F17F02 with immediate ack.
  - LB at `off`=3 → 0xFFFFFF80; LBU at `off`=3 → 0x00000080.
  - LH at `off`=2 → 0xFFFF80F1; LHU at `off`=0 → 0x00007F02.
  - Each has `done` exactly 2 cycles after `start`.
- Faults:
  - LW at `addr`=0x102 → `done`=`err`=1 next cycle, `mem_req` never asserted.
  - SH at 0x101 → same response.
  - Store with `funct3`=100 → same response.
  - For all three, `load_data` is unchanged.
- Back-to-back and ignored starts:
  - A second `start` issued in the `done` cycle is accepted.
  - A `start` pulsed while `busy`=1 produces no extra transaction.
- Reset asserted during ACCESS with `mem_ready` low.
  - `mem_req` and `busy` go to 0 asynchronously.
  - No `done` afterwards.
  - Next `start` completes normally.
